// File: rtl/col_scan_pkg.sv
// Shared definitions for the column scan sequencer: state encodings, select width,
// default timing parameters and the column-advance helper.
package col_scan_pkg;

    localparam int SEL_W = 3;

    localparam int unsigned DEF_CLK_DIV   = 50000;
    localparam int unsigned DEF_NUM_COLS  = 5;
    localparam int unsigned DEF_BLANK_CYC = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHOW  = 2'd1,
        ST_BLANK = 2'd2
    } state_t;

    // Next column index, wrapping NUM_COLS-1 back to 0.
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] s,
                                                  input int unsigned      n);
        return (32'(s) == n - 1) ? '0 : s + 1'b1;
    endfunction

endpackage

// File: rtl/scan_prescaler.sv
// Show-period counter: counts 0..DIV-1 while enabled, synchronous clear wins,
// o_tc pulses in the last counted cycle.
module scan_prescaler #(
    parameter int unsigned DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic i_clr,
    input  logic i_en,
    output logic o_tc
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;

    logic [W-1:0] r_cnt;

    assign o_tc = i_en && (r_cnt == W'(DIV - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_cnt <= '0;
        else if (i_clr)
            r_cnt <= '0;
        else if (i_en)
            r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
    end

endmodule

// File: rtl/col_scan.sv
// Column scan sequencer for the LED display. Blanking gap between columns is
// compiled in with `define COL_SCAN_BLANK_EN; otherwise columns switch back to back.
module col_scan
    import col_scan_pkg::*;
#(
    parameter int unsigned CLK_DIV   = DEF_CLK_DIV,
    parameter int unsigned NUM_COLS  = DEF_NUM_COLS,
    parameter int unsigned BLANK_CYC = DEF_BLANK_CYC
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             enable,
    input  logic             restart,
    output logic [SEL_W-1:0] sel,
    output logic             col_valid,
    output logic             frame_start
);

    state_t           r_state, w_nstate;
    logic [SEL_W-1:0] r_sel, w_nsel;
    logic             r_col_valid, w_ncol_valid;
    logic             r_frame_start, w_nfs;
    logic             w_enter_show;
    logic             w_tc;

    scan_prescaler #(.DIV(CLK_DIV)) u_presc (
        .clk   (clk),
        .rst_n (rst_n),
        .i_clr (w_enter_show),
        .i_en  (r_state == ST_SHOW),
        .o_tc  (w_tc)
    );

`ifdef COL_SCAN_BLANK_EN
    localparam int BW = (BLANK_CYC > 1) ? $clog2(BLANK_CYC) : 1;

    logic [BW-1:0] r_blank_cnt;
    logic          w_blank_done;

    assign w_blank_done = (r_blank_cnt == BW'(BLANK_CYC - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_blank_cnt <= '0;
        else if (r_state == ST_BLANK && w_nstate == ST_BLANK)
            r_blank_cnt <= r_blank_cnt + 1'b1;
        else
            r_blank_cnt <= '0;
    end
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state       <= ST_IDLE;
            r_sel         <= '0;
            r_col_valid   <= 1'b0;
            r_frame_start <= 1'b0;
        end else begin
            r_state       <= w_nstate;
            r_sel         <= w_nsel;
            r_col_valid   <= w_ncol_valid;
            r_frame_start <= w_nfs;
        end
    end

    // Every SHOW entry clears the prescaler so each column gets a full period.
    always_comb begin
        w_nstate     = r_state;
        w_nsel       = r_sel;
        w_enter_show = 1'b0;
        if (!enable) begin
            w_nstate = ST_IDLE;
            w_nsel   = '0;
        end else if (restart) begin
            w_nstate     = ST_SHOW;
            w_nsel       = '0;
            w_enter_show = 1'b1;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    w_nstate     = ST_SHOW;
                    w_nsel       = '0;
                    w_enter_show = 1'b1;
                end
                ST_SHOW: begin
                    if (w_tc) begin
`ifdef COL_SCAN_BLANK_EN
                        w_nstate     = ST_BLANK;
`else
                        w_nstate     = ST_SHOW;
                        w_nsel       = next_sel(r_sel, NUM_COLS);
                        w_enter_show = 1'b1;
`endif
                    end
                end
`ifdef COL_SCAN_BLANK_EN
                ST_BLANK: begin
                    if (w_blank_done) begin
                        w_nstate     = ST_SHOW;
                        w_nsel       = next_sel(r_sel, NUM_COLS);
                        w_enter_show = 1'b1;
                    end
                end
`endif
                default: begin
                    w_nstate = ST_IDLE;
                    w_nsel   = '0;
                end
            endcase
        end
    end

    // Frame start marks every SHOW entry that lands on column 0.
    always_comb begin
        w_ncol_valid = (w_nstate == ST_SHOW);
        w_nfs        = w_enter_show && (w_nsel == '0);
    end

    assign sel         = r_sel;
    assign col_valid   = r_col_valid;
    assign frame_start = r_frame_start;

endmodule
